// File: rtl/cdclib_graytobin_inc2_sync.sv
// Receive-side sync + decode for inc-by-2 Gray pointers; registers value and advance delta.
// Optional legality check enabled by defining CDCLIB_GRAY_INC2_CHECK_EN.
module cdclib_graytobin_inc2_sync #(
    parameter int WIDTH     = 4,
    parameter int NUM_SYNC  = 2,
    parameter int MAX_DELTA = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta_out,
    output logic             bin_inc,
    output logic             gray_err
);

    logic [WIDTH-1:0] sync [NUM_SYNC];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] delta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_SYNC; k++) sync[k] <= '0;
        end else begin
            sync[0] <= gray_in;
            for (int k = 1; k < NUM_SYNC; k++) sync[k] <= sync[k-1];
        end
    end

    assign s = sync[NUM_SYNC-1];

    // Prefix-XOR from the MSB; bit 0 is the constant-zero LSB of the count.
    always_comb begin
        b = '0;
        b[WIDTH-1] = s[WIDTH-1];
        for (int i = WIDTH - 2; i >= 1; i--) b[i] = b[i+1] ^ s[i];
    end

    assign delta = b - bin_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out   <= '0;
            delta_out <= '0;
            bin_inc   <= 1'b0;
        end else begin
            bin_out   <= b;
            delta_out <= delta;
            bin_inc   <= (b != bin_out);
        end
    end

`ifdef CDCLIB_GRAY_INC2_CHECK_EN
    localparam logic [WIDTH-1:0] MAXD = WIDTH'(MAX_DELTA);

    logic err_set;

    assign err_set = s[0] | (delta > MAXD);

    // A fresh error outranks a clear arriving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_err <= 1'b0;
        end else if (err_set) begin
            gray_err <= 1'b1;
        end else if (err_clr) begin
            gray_err <= 1'b0;
        end
    end
`else
    logic unused_chk;

    assign unused_chk = ^{err_clr, s[0], MAX_DELTA[0]};
    assign gray_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cdclib_graytobin_inc2_sync.sv
// Scoreboard bench for cdclib_graytobin_inc2_sync (WIDTH=4, NUM_SYNC=2).
// Two instances share inputs: MAX_DELTA=2 and MAX_DELTA=6.
module tb_cdclib_graytobin_inc2_sync;

`ifdef CDCLIB_GRAY_INC2_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] delta;
        logic       inc;
        logic       set2;
        logic       set6;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gray_in = '0;
    logic       err_clr = 1'b0;
    logic [3:0] bin_out, delta_out, bin6, delta6;
    logic       bin_inc, gray_err, inc6, gray_err6;

    int   total = 0;
    int   bad = 0;
    bit   sb_on = 1'b0;
    exp_t q[$];
    logic [3:0] m_prev = '0;
    logic err2_m = 1'b0;
    logic err6_m = 1'b0;
    logic clr_prev = 1'b0;

    always #5 clk = ~clk;

    cdclib_graytobin_inc2_sync #(.WIDTH(4), .NUM_SYNC(2), .MAX_DELTA(2)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .bin_out(bin_out), .delta_out(delta_out),
        .bin_inc(bin_inc), .gray_err(gray_err)
    );

    cdclib_graytobin_inc2_sync #(.WIDTH(4), .NUM_SYNC(2), .MAX_DELTA(6)) dut6 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .bin_out(bin6), .delta_out(delta6),
        .bin_inc(inc6), .gray_err(gray_err6)
    );

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [2:0] u;
        u = g[3:1];
        u = u ^ (u >> 1) ^ (u >> 2);
        return {u, 1'b0};
    endfunction

    function automatic void push(input logic [3:0] g);
        exp_t e;
        logic [3:0] b;
        b = g2b(g);
        e.bin   = b;
        e.delta = b - m_prev;
        e.inc   = (e.delta != 4'd0);
        e.set2  = CHK & (g[0] | (e.delta > 4'd2));
        e.set6  = CHK & (g[0] | (e.delta > 4'd6));
        m_prev  = b;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_on) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: queue empty at %0t", $time);
            end else begin
                e = q.pop_front();
                err2_m = e.set2 | (err2_m & ~clr_prev);
                err6_m = e.set6 | (err6_m & ~clr_prev);
                total += 5;
                if (bin_out !== e.bin) begin
                    bad++;
                    $display("FAIL sb_bin: got %h want %h @%0t", bin_out, e.bin, $time);
                end
                if (delta_out !== e.delta) begin
                    bad++;
                    $display("FAIL sb_delta: got %h want %h @%0t", delta_out, e.delta, $time);
                end
                if (bin_inc !== e.inc) begin
                    bad++;
                    $display("FAIL sb_inc: got %b want %b @%0t", bin_inc, e.inc, $time);
                end
                if (gray_err !== err2_m) begin
                    bad++;
                    $display("FAIL sb_err2: got %b want %b @%0t", gray_err, err2_m, $time);
                end
                if (gray_err6 !== err6_m) begin
                    bad++;
                    $display("FAIL sb_err6: got %b want %b @%0t", gray_err6, err6_m, $time);
                end
            end
        end
        clr_prev = err_clr;
    end

    task automatic tick(input logic [3:0] g, input logic clr = 1'b0);
        @(posedge clk);
        #2;
        gray_in = g;
        err_clr = clr;
        push(g);
    endtask

    task automatic hold(input logic [3:0] g, input int n, input logic clr = 1'b0);
        for (int i = 0; i < n; i++) tick(g, clr);
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        rst = 1'b1;
        gray_in = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({bin_out, delta_out, bin_inc, gray_err, gray_err6} !== 11'd0) begin
            bad++;
            $display("FAIL reset_hold: got %h/%h/%b/%b/%b want 0",
                     bin_out, delta_out, bin_inc, gray_err, gray_err6);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        q.delete();
        m_prev = '0;
        err2_m = 1'b0;
        err6_m = 1'b0;
        clr_prev = 1'b0;
        for (int i = 0; i < 4; i++) q.push_back(exp_t'(0));
        sb_on = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        hold(4'b0000, 4);
        total++;
        if ({bin_out, delta_out, bin_inc} !== 9'd0) begin
            bad++;
            $display("FAIL reset_release: got %h/%h/%b want 0", bin_out, delta_out, bin_inc);
        end
    endtask

    task automatic test_latency();
        tick(4'b0010);
        tick(4'b0010);
        tick(4'b0010);
        total++;
        if (bin_out !== 4'd0) begin
            bad++;
            $display("FAIL lat_early: got %h want 0", bin_out);
        end
        tick(4'b0010);
        total++;
        if ({bin_out, delta_out, bin_inc} !== {4'd2, 4'd2, 1'b1}) begin
            bad++;
            $display("FAIL lat_edge3: got %h/%h/%b want 2/2/1", bin_out, delta_out, bin_inc);
        end
        tick(4'b0010);
        total++;
        if ({delta_out, bin_inc} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL lat_pulse: got %h/%b want 0/0", delta_out, bin_inc);
        end
        hold(4'b0010, 2);
    endtask

    task automatic test_sequence();
        logic [3:0] seq [9];
        seq = '{4'b0000, 4'b0010, 4'b0110, 4'b0100, 4'b1100,
                4'b1110, 4'b1010, 4'b1000, 4'b0000};
        do_reset();
        for (int i = 0; i < 9; i++) hold(seq[i], 4);
        total++;
        if (bin_out !== 4'd0) begin
            bad++;
            $display("FAIL wrap_end: got %h want 0", bin_out);
        end
    endtask

    task automatic test_multi_step();
        do_reset();
        hold(4'b0010, 4);
        tick(4'b0100);
        hold(4'b0100, 3);
        total++;
        if (gray_err !== CHK || gray_err6 !== 1'b0) begin
            bad++;
            $display("FAIL multi_err: got %b/%b want %b/0", gray_err, gray_err6, CHK);
        end
    endtask

    task automatic test_illegal_lsb();
        do_reset();
        hold(4'b0001, 6);
        hold(4'b0000, 4);
        tick(4'b0000, 1'b1);
        hold(4'b0000, 4);
        total++;
        if (gray_err !== 1'b0) begin
            bad++;
            $display("FAIL lsb_clear: got %b want 0", gray_err);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        hold(4'b0010, 4, 1'b1);
        hold(4'b0100, 6, 1'b1);
        hold(4'b0100, 3);
    endtask

    task automatic test_mid_reset();
        do_reset();
        hold(4'b1110, 5);
        sb_on = 1'b0;
        total++;
        if (bin_out !== 4'b1010 || gray_err !== CHK) begin
            bad++;
            $display("FAIL mid_pre: got %h/%b want a/%b", bin_out, gray_err, CHK);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bin_out, delta_out, bin_inc, gray_err, gray_err6} !== 11'd0) begin
            bad++;
            $display("FAIL mid_async: got %h/%h/%b/%b want 0",
                     bin_out, delta_out, bin_inc, gray_err);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bin_out, delta_out, bin_inc, gray_err, gray_err6} !== 11'd0) begin
            bad++;
            $display("FAIL mid_held: got %h/%h/%b/%b want 0",
                     bin_out, delta_out, bin_inc, gray_err);
        end
        do_reset();
        hold(4'b0000, 5);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sequence();
        test_multi_step();
        test_illegal_lsb();
        test_set_wins();
        test_mid_reset();
        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
